// File: rtl/flex_counter_pkg.sv
// rtl/flex_counter_pkg.sv - shared types and constants for the flexible up/down counter
package flex_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_NUM_BITS      = 4;
  localparam int DEF_PRESCALE_BITS = 4;

endpackage

// File: rtl/flex_updown_counter_if.sv
// rtl/flex_updown_counter_if.sv - control and status bundle of the flexible up/down counter
interface flex_updown_counter_if
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS      = DEF_NUM_BITS,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
);

  logic                     clear;
  logic                     count_enable;
  logic                     up_down;
  logic                     mode;
  logic                     load;
  logic [NUM_BITS-1:0]      load_val;
  logic [NUM_BITS-1:0]      rollover_val;
  logic [PRESCALE_BITS-1:0] prescale_val;
  logic [NUM_BITS-1:0]      count_out;
  logic                     rollover_flag;
  logic                     wrap_pulse;

  modport master (
    output clear, count_enable, up_down, mode, load, load_val, rollover_val, prescale_val,
    input  count_out, rollover_flag, wrap_pulse
  );

  modport slave (
    input  clear, count_enable, up_down, mode, load, load_val, rollover_val, prescale_val,
    output count_out, rollover_flag, wrap_pulse
  );

endinterface

// File: rtl/flex_prescaler.sv
// rtl/flex_prescaler.sv - enable divider producing one step every prescale_val+1 enabled cycles
module flex_prescaler
  import flex_counter_pkg::*;
#(
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     step
);

  logic [PRESCALE_BITS-1:0] cnt_q;
  logic                     hit;

  assign hit  = (cnt_q == prescale_val);
  assign step = count_enable && hit && !clear;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_enable) begin
      cnt_q <= hit ? '0 : cnt_q + PRESCALE_BITS'(1);
    end
  end

endmodule

// File: rtl/flex_updown_counter.sv
// rtl/flex_updown_counter.sv - prescaled up/down counter with wrap or saturate terminal behaviour
module flex_updown_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS      = DEF_NUM_BITS,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);

  logic [NUM_BITS-1:0] count_q;
  logic [NUM_BITS-1:0] count_nxt;
  logic                flag_q;
  logic                flag_nxt;
  logic                wrap_q;
  logic                wrap_nxt;
  logic                step;

  // Load restarts the prescale window just like clear does.
  flex_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bus.clear | bus.load),
    .count_enable (bus.count_enable),
    .prescale_val (bus.prescale_val),
    .step         (step)
  );

  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    if (bus.clear) begin
      count_nxt = '0;
    end else if (bus.load) begin
      count_nxt = bus.load_val;
    end else if (step) begin
      if (bus.rollover_val == '0) begin
        count_nxt = '0;
      end else if (bus.up_down == DIR_UP) begin
        if (count_q >= bus.rollover_val) begin
          if (mode_e'(bus.mode) == MODE_WRAP) begin
            count_nxt = NUM_BITS'(1);
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count_q + NUM_BITS'(1);
        end
      end else if (bus.up_down == DIR_DOWN) begin
        if (count_q <= NUM_BITS'(1)) begin
          if (mode_e'(bus.mode) == MODE_WRAP) begin
            count_nxt = bus.rollover_val;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count_q - NUM_BITS'(1);
        end
      end
    end
    flag_nxt = (count_nxt == bus.rollover_val) && (bus.rollover_val != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      flag_q  <= flag_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = flag_q;
  assign bus.wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// tb/tb_flex_updown_counter.sv - self-checking bench for flex_updown_counter with a reference model
module tb_flex_updown_counter;

  localparam int NB = 8;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic n_rst;

  flex_updown_counter_if #(.NUM_BITS(NB), .PRESCALE_BITS(PB)) bus ();

  flex_updown_counter #(.NUM_BITS(NB), .PRESCALE_BITS(PB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: count value, enabled-cycle position inside the prescale window, flags.
  int m_cnt, m_psc, m_flag, m_wrap;

  task automatic model_reset();
    m_cnt = 0; m_psc = 0; m_flag = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    int rv  = int'(bus.rollover_val);
    int nxt = m_cnt;
    bit stp = 1'b0;
    bit wr  = 1'b0;
    if (bus.clear) begin
      nxt = 0; m_psc = 0;
    end else if (bus.load) begin
      nxt = int'(bus.load_val); m_psc = 0;
    end else if (bus.count_enable) begin
      stp   = (m_psc == int'(bus.prescale_val));
      m_psc = stp ? 0 : (m_psc + 1) % (1 << PB);
    end
    if (stp) begin
      if (rv == 0) nxt = 0;
      else if (bus.up_down) begin
        if (m_cnt < rv) nxt = m_cnt + 1;
        else if (!bus.mode) begin nxt = 1; wr = 1'b1; end
      end else begin
        if (m_cnt > 1) nxt = m_cnt - 1;
        else if (!bus.mode) begin nxt = rv; wr = 1'b1; end
      end
    end
    m_cnt  = nxt;
    m_flag = (rv != 0 && nxt == rv) ? 1 : 0;
    m_wrap = wr ? 1 : 0;
  endtask

  task automatic run_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.clear = 0; bus.load = 0; bus.count_enable = 1; bus.up_down = 1; bus.mode = 0;
    bus.load_val = '0; bus.rollover_val = 8'd9; bus.prescale_val = '0;
    model_reset();
    #2;
    checks++;
    if (bus.count_out !== 8'd0 || bus.rollover_flag !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: count=%0d flag=%0b wrap=%0b required 0/0/0",
               bus.count_out, bus.rollover_flag, bus.wrap_pulse);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.count_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_held_over_edge: count=%0d required 0", bus.count_out);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.count_enable = 0; bus.clear = 1;
    run_cycle();
    bus.clear = 0; bus.count_enable = 1;
    repeat (5) run_cycle();
    checks++;
    if (bus.count_out !== 8'd5) begin
      errors++;
      $display("FAIL async_pre_count: count=%0d required 5", bus.count_out);
    end
    #1 n_rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.count_out !== 8'd0 || bus.rollover_flag !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: count=%0d flag=%0b wrap=%0b required 0/0/0",
               bus.count_out, bus.rollover_flag, bus.wrap_pulse);
    end
    #2 n_rst = 1'b1;
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd1) begin
      errors++;
      $display("FAIL async_first_step: count=%0d required 1", bus.count_out);
    end
  endtask

  task automatic test_wrap_up();
    bus.rollover_val = 8'd200; bus.up_down = 1; bus.mode = 0; bus.prescale_val = '0;
    bus.clear = 1;
    run_cycle();
    bus.clear = 0;
    repeat (200) run_cycle();
    checks++;
    if (bus.count_out !== 8'd200 || bus.rollover_flag !== 1'b1 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_terminal: count=%0d flag=%0b wrap=%0b required 200/1/0",
               bus.count_out, bus.rollover_flag, bus.wrap_pulse);
    end
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd1 || bus.rollover_flag !== 1'b0 || bus.wrap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up_wrapped: count=%0d flag=%0b wrap=%0b required 1/0/1",
               bus.count_out, bus.rollover_flag, bus.wrap_pulse);
    end
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd2 || bus.wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_pulse_end: count=%0d wrap=%0b required 2/0",
               bus.count_out, bus.wrap_pulse);
    end
  endtask

  task automatic test_down_wrap();
    int exp_cnt[4]  = '{2, 1, 9, 8};
    int exp_flag[4] = '{0, 0, 1, 0};
    int exp_wrap[4] = '{0, 0, 1, 0};
    bus.rollover_val = 8'd9; bus.up_down = 0; bus.mode = 0;
    bus.load = 1; bus.load_val = 8'd3;
    run_cycle();
    bus.load = 0;
    checks++;
    if (bus.count_out !== 8'd3) begin
      errors++;
      $display("FAIL down_load: count=%0d required 3", bus.count_out);
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      checks++;
      if (int'(bus.count_out) != exp_cnt[i] || int'(bus.rollover_flag) != exp_flag[i] ||
          int'(bus.wrap_pulse) != exp_wrap[i]) begin
        errors++;
        $display("FAIL down_wrap_step%0d: count=%0d flag=%0b wrap=%0b required %0d/%0d/%0d", i,
                 bus.count_out, bus.rollover_flag, bus.wrap_pulse, exp_cnt[i], exp_flag[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int wrap_seen = 0;
    bus.rollover_val = 8'd5; bus.up_down = 1; bus.mode = 1;
    bus.clear = 1;
    run_cycle();
    bus.clear = 0;
    repeat (10) begin
      run_cycle();
      if (bus.wrap_pulse !== 1'b0) wrap_seen++;
    end
    checks++;
    if (bus.count_out !== 8'd5 || bus.rollover_flag !== 1'b1 || wrap_seen != 0) begin
      errors++;
      $display("FAIL saturate_up: count=%0d flag=%0b wraps=%0d required 5/1/0",
               bus.count_out, bus.rollover_flag, wrap_seen);
    end
  endtask

  task automatic test_prescale();
    bus.rollover_val = 8'd9; bus.up_down = 1; bus.mode = 0; bus.prescale_val = 4'd2;
    bus.clear = 1;
    run_cycle();
    bus.clear = 0;
    repeat (9) run_cycle();
    checks++;
    if (bus.count_out !== 8'd3) begin
      errors++;
      $display("FAIL prescale_nine: count=%0d required 3", bus.count_out);
    end
    bus.count_enable = 0;
    repeat (4) run_cycle();
    checks++;
    if (bus.count_out !== 8'd3) begin
      errors++;
      $display("FAIL prescale_disabled: count=%0d required 3", bus.count_out);
    end
    bus.count_enable = 1;
    repeat (2) run_cycle();
    checks++;
    if (bus.count_out !== 8'd3) begin
      errors++;
      $display("FAIL prescale_partial: count=%0d required 3", bus.count_out);
    end
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd4) begin
      errors++;
      $display("FAIL prescale_reenable: count=%0d required 4", bus.count_out);
    end
  endtask

  task automatic test_priority();
    bus.clear = 1; bus.load = 1; bus.load_val = 8'd7; bus.count_enable = 1;
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd0 || bus.rollover_flag !== 1'b0) begin
      errors++;
      $display("FAIL priority_clear_load: count=%0d flag=%0b required 0/0",
               bus.count_out, bus.rollover_flag);
    end
    bus.clear = 0;
    run_cycle();
    bus.load = 0;
    checks++;
    if (bus.count_out !== 8'd7) begin
      errors++;
      $display("FAIL priority_load: count=%0d required 7", bus.count_out);
    end
    repeat (2) run_cycle();
    checks++;
    if (bus.count_out !== 8'd7) begin
      errors++;
      $display("FAIL load_prescale_restart: count=%0d required 7", bus.count_out);
    end
    run_cycle();
    checks++;
    if (bus.count_out !== 8'd8) begin
      errors++;
      $display("FAIL load_first_step: count=%0d required 8", bus.count_out);
    end
    bus.load = 1; bus.load_val = 8'd9;
    run_cycle();
    bus.load = 0;
    checks++;
    if (bus.count_out !== 8'd9 || bus.rollover_flag !== 1'b1) begin
      errors++;
      $display("FAIL load_flag: count=%0d flag=%0b required 9/1", bus.count_out, bus.rollover_flag);
    end
  endtask

  task automatic test_random();
    bus.clear = 1;
    run_cycle();
    for (int i = 0; i < 3000; i++) begin
      bus.clear        = ($urandom_range(0, 31) == 0);
      bus.load         = ($urandom_range(0, 15) == 0);
      bus.load_val     = NB'($urandom_range(0, 15));
      bus.count_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) bus.up_down = 1'($urandom);
      if ($urandom_range(0, 29) == 0) bus.mode = 1'($urandom);
      if ($urandom_range(0, 49) == 0)
        bus.rollover_val = ($urandom_range(0, 7) == 0) ? NB'($urandom_range(0, 255))
                                                       : NB'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) bus.prescale_val = PB'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.count_out !== 8'd0 || bus.rollover_flag !== 1'b0 || bus.wrap_pulse !== 1'b0) begin
          errors++;
          $display("FAIL random_async_reset@%0d: count=%0d flag=%0b wrap=%0b required 0/0/0", i,
                   bus.count_out, bus.rollover_flag, bus.wrap_pulse);
        end
        n_rst = 1'b1;
      end
      run_cycle();
      checks++;
      if (int'(bus.count_out) != m_cnt || int'(bus.rollover_flag) != m_flag ||
          int'(bus.wrap_pulse) != m_wrap) begin
        errors++;
        $display("FAIL random_cycle%0d: count=%0d flag=%0b wrap=%0b required %0d/%0d/%0d", i,
                 bus.count_out, bus.rollover_flag, bus.wrap_pulse, m_cnt, m_flag, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_wrap_up();
    test_down_wrap();
    test_saturate();
    test_prescale();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flex_updown_counter.md
FLEX_UPDOWN_COUNTER -- requirements
Module: flex_updown_counter

Interface
REQ-001 Parameter NUM_BITS, default 4, width of count_out, rollover_val and load_val.
REQ-002 Parameter PRESCALE_BITS, default 4, width of prescale_val and the internal prescale counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous clear of count and prescaler.
REQ-006 count_enable  input  1  permits prescaler advance and count steps.
REQ-007 up_down  input  1  direction: 1 = up, 0 = down.
REQ-008 mode  input  1  terminal behaviour: 0 = wrap, 1 = saturate.
REQ-009 load  input  1  synchronous load of load_val into count_out.
REQ-010 load_val  input  NUM_BITS  value to load.
REQ-011 rollover_val  input  NUM_BITS  terminal count; legal range is 1..rollover_val.
REQ-012 prescale_val  input  PRESCALE_BITS  steps occur once every prescale_val+1 enabled cycles.
REQ-013 count_out  output  NUM_BITS  registered count.
REQ-014 rollover_flag  output  1  registered; high while count_out == rollover_val.
REQ-015 wrap_pulse  output  1  registered one-cycle pulse after each wrap step.

Function
REQ-016 Per-edge priority: clear > load > step > hold.
REQ-017 clear: count_out <= 0, prescale counter <= 0, wrap_pulse <= 0.
REQ-018 load (clear low): count_out <= load_val, prescale counter <= 0; no step that cycle.
REQ-019 Prescaler: when count_enable is high, the prescale counter compares equal to prescale_val, and clear and load are both low, a step occurs and the prescaler resets to 0; otherwise, when enabled, the prescaler increments; when disabled, it holds.
REQ-020 prescale_val = 0 gives one step per enabled cycle (legacy counter behaviour).
REQ-021 Up step:
- count_out >= rollover_val, wrap mode: count_out <= 1 and the step is a wrap.
- count_out >= rollover_val, saturate mode: count holds.
- otherwise: count_out + 1.
REQ-022 Down step:
- count_out <= 1, wrap mode: count_out <= rollover_val and the step is a wrap.
- count_out <= 1, saturate mode: count holds.
- otherwise: count_out - 1.
REQ-023 rollover_val = 0: any step forces count_out to 0; no wrap is signalled.
REQ-024 rollover_flag <= (next count == rollover_val) && (rollover_val != 0), evaluated every edge, including hold, clear and load edges.
REQ-025 wrap_pulse is high for exactly the one cycle following a wrap step, and low otherwise.
REQ-026 Arithmetic is NUM_BITS unsigned; no result ever leaves the 0..2^NUM_BITS-1 range.
REQ-027 Changing up_down, mode or rollover_val mid-count takes effect at the next step with no extra latency.

Reset
REQ-028 n_rst low asynchronously forces count_out = 0, rollover_flag = 0, wrap_pulse = 0 and prescale counter = 0, independent of clk.
REQ-029 Reset asserted mid-count or mid-prescale discards all progress; the first step after release requires a full prescale_val+1 enabled cycles.

Structure
REQ-030 Package flex_counter_pkg holds:
- the mode enum (MODE_WRAP = 0, MODE_SAT = 1);
- direction constants DIR_UP = 1 and DIR_DOWN = 0;
- default NUM_BITS and PRESCALE_BITS constants.
REQ-031 Sub-module flex_prescaler (ports clk, n_rst, clear, count_enable, prescale_val, step) implements REQ-019, REQ-020 and REQ-029.
REQ-032 Next-state logic is combinational, with one registered always_ff block for count_out, rollover_flag and wrap_pulse.

Verification
REQ-033 Async reset: count to 5, drop n_rst mid-cycle -> count_out = 0 and flags = 0 before the next rising edge; release, then the first step occurs on the first enabled edge.
REQ-034 NUM_BITS = 8, up, wrap, rollover_val = 200, prescale 0:
- after 200 enabled cycles -> count_out = 200, rollover_flag = 1;
- next cycle -> count_out = 1, rollover_flag = 0, wrap_pulse = 1 for one cycle.
REQ-035 Down wrap: load 3 with rollover_val = 9 -> steps give 2, 1, then 9 with rollover_flag = 1, then wrap_pulse = 1 for one cycle, then 8.
REQ-036 Saturate up, rollover_val = 5, 10 enabled cycles -> count_out = 5, rollover_flag = 1, wrap_pulse never asserted.
REQ-037 prescale_val = 2, rollover_val = 9:
- 9 enabled cycles -> count_out = 3;
- deassert enable for 4 cycles -> count_out stays 3;
- re-enable for 3 cycles -> count_out = 4.
REQ-038 Priority:
- clear and load in the same cycle -> count_out = 0;
- load = 7 with count_enable high -> count_out = 7, prescaler = 0.
